// File: rtl/parking_exit_gate.sv
// parking_exit_gate: exit-lane barrier controller.
// Detects a vehicle at the exit, validates a 2-bit payment code with a retry
// limit and attendant override, opens the barrier for a bounded window and
// issues a one-cycle car_exited decrement request to the occupancy counter.
// All outputs are registered; they are decoded from the next state so they
// line up with the state register and carry no input-to-output path.
module parking_exit_gate #(
  parameter logic [1:0] PAY_CODE    = 2'b11,
  parameter int         MAX_TRIES   = 3,
  parameter int         GATE_CYCLES = 16,
  parameter int         OCC_W       = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sensor_exit,
  input  logic             sensor_clear,
  input  logic             pay_valid,
  input  logic [1:0]       pay_code,
  input  logic             attendant_ok,
  input  logic [OCC_W-1:0] occupancy,
  output logic             GREEN_LED,
  output logic             RED_LED,
  output logic             gate_open,
  output logic             alarm,
  output logic             car_exited
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_PAY  = 3'd1,
    WRONG_PAY = 3'd2,
    OPEN      = 3'd3,
    LOCKOUT   = 3'd4
  } state_t;

  localparam logic [2:0] TRIES_LIMIT = 3'(MAX_TRIES);
  localparam logic [7:0] TIMER_LAST  = 8'(GATE_CYCLES - 1);

  state_t     state_r;
  state_t     state_nx;
  logic [2:0] tries_r;
  logic [2:0] tries_nx;
  logic [7:0] timer_r;
  logic [7:0] timer_nx;
  logic       exited_nx;
  logic       occ_nonzero_s;
  logic [2:0] tries_inc_s;

  assign occ_nonzero_s = |occupancy;
  assign tries_inc_s   = tries_r + 3'd1;

  // Next-state, retry counter, open timer and exit pulse decision.
  always_comb begin
    state_nx  = state_r;
    tries_nx  = tries_r;
    timer_nx  = timer_r;
    exited_nx = 1'b0;
    case (state_r)
      IDLE: begin
        tries_nx = 3'd0;
        if (sensor_exit) begin
          if (occ_nonzero_s) begin
            state_nx = WAIT_PAY;
          end else begin
            // A vehicle at the exit with an empty car park is a phantom.
            state_nx = LOCKOUT;
          end
        end else begin
          state_nx = IDLE;
        end
      end
      WAIT_PAY, WRONG_PAY: begin
        if (attendant_ok) begin
          state_nx = OPEN;
          tries_nx = 3'd0;
          timer_nx = 8'd0;
        end else if (pay_valid && (pay_code == PAY_CODE)) begin
          state_nx = OPEN;
          tries_nx = 3'd0;
          timer_nx = 8'd0;
        end else if (pay_valid) begin
          tries_nx = tries_inc_s;
          if (tries_inc_s == TRIES_LIMIT) begin
            state_nx = LOCKOUT;
          end else begin
            state_nx = WRONG_PAY;
          end
        end else if (!sensor_exit) begin
          state_nx = IDLE;
          tries_nx = 3'd0;
        end else begin
          state_nx = state_r;
        end
      end
      OPEN: begin
        if (sensor_clear) begin
          state_nx  = IDLE;
          tries_nx  = 3'd0;
          // Never ask the counter to go below zero.
          exited_nx = occ_nonzero_s;
        end else if (timer_r == TIMER_LAST) begin
          if (sensor_exit) begin
            // Barrier must not close on a vehicle still under it.
            state_nx = OPEN;
          end else begin
            state_nx = IDLE;
            tries_nx = 3'd0;
          end
        end else begin
          timer_nx = timer_r + 8'd1;
        end
      end
      LOCKOUT: begin
        if (attendant_ok) begin
          state_nx = OPEN;
          tries_nx = 3'd0;
          timer_nx = 8'd0;
        end else begin
          state_nx = LOCKOUT;
        end
      end
      default: begin
        state_nx = IDLE;
        tries_nx = 3'd0;
        timer_nx = 8'd0;
      end
    endcase
  end

  // State, counters and registered output decode of the upcoming state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      tries_r    <= 3'd0;
      timer_r    <= 8'd0;
      GREEN_LED  <= 1'b0;
      RED_LED    <= 1'b0;
      gate_open  <= 1'b0;
      alarm      <= 1'b0;
      car_exited <= 1'b0;
    end else begin
      state_r    <= state_nx;
      tries_r    <= tries_nx;
      timer_r    <= timer_nx;
      car_exited <= exited_nx;
      GREEN_LED  <= (state_nx == OPEN);
      gate_open  <= (state_nx == OPEN);
      RED_LED    <= (state_nx == WRONG_PAY) || (state_nx == LOCKOUT);
      alarm      <= (state_nx == LOCKOUT);
    end
  end

endmodule

// File: tb/tb_parking_exit_gate.sv
// tb_parking_exit_gate: scoreboard bench for the exit gate controller.
// A driver applies directed and random stimulus, steps an abstract model of
// the lane and queues the expected output vector; a monitor pops and
// compares it one cycle later.
module tb_parking_exit_gate;

  localparam int GATE = 16;
  localparam int MAXT = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       sensor_exit;
  logic       sensor_clear;
  logic       pay_valid;
  logic [1:0] pay_code;
  logic       attendant_ok;
  logic [6:0] occupancy;
  logic       GREEN_LED;
  logic       RED_LED;
  logic       gate_open;
  logic       alarm;
  logic       car_exited;

  int total = 0;
  int bad   = 0;

  // expected vector: {GREEN_LED, RED_LED, gate_open, alarm, car_exited}
  logic [4:0] exp_q[$];
  logic [4:0] mon_e;

  // abstract lane model
  bit m_open;
  bit m_locked;
  bit m_paying;
  int m_wrong;
  int m_age;

  parking_exit_gate #(
    .PAY_CODE   (2'b11),
    .MAX_TRIES  (MAXT),
    .GATE_CYCLES(GATE),
    .OCC_W      (7)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sensor_exit (sensor_exit),
    .sensor_clear(sensor_clear),
    .pay_valid   (pay_valid),
    .pay_code    (pay_code),
    .attendant_ok(attendant_ok),
    .occupancy   (occupancy),
    .GREEN_LED   (GREEN_LED),
    .RED_LED     (RED_LED),
    .gate_open   (gate_open),
    .alarm       (alarm),
    .car_exited  (car_exited)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] outs();
    return {GREEN_LED, RED_LED, gate_open, alarm, car_exited};
  endfunction

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %b expected %b (G R gate alarm exit) at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    m_open   = 1'b0;
    m_locked = 1'b0;
    m_paying = 1'b0;
    m_wrong  = 0;
    m_age    = 0;
  endtask

  // One clock of lane behaviour; returns the outputs expected after the edge.
  function automatic logic [4:0] model_step(input bit se, input bit sc, input bit pv,
                                            input logic [1:0] pc, input bit at,
                                            input logic [6:0] oc);
    bit exited = 1'b0;
    bit red;
    if (m_open) begin
      if (sc) begin
        m_open = 1'b0;
        exited = (oc != 7'd0);
      end else if (m_age == GATE - 1) begin
        if (!se) m_open = 1'b0;
      end else begin
        m_age++;
      end
    end else if (m_locked) begin
      if (at) begin
        m_locked = 1'b0;
        m_open   = 1'b1;
        m_age    = 0;
        m_wrong  = 0;
      end
    end else if (m_paying) begin
      if (at || (pv && pc == 2'b11)) begin
        m_paying = 1'b0;
        m_open   = 1'b1;
        m_age    = 0;
        m_wrong  = 0;
      end else if (pv) begin
        m_wrong++;
        if (m_wrong == MAXT) begin
          m_paying = 1'b0;
          m_locked = 1'b1;
        end
      end else if (!se) begin
        m_paying = 1'b0;
        m_wrong  = 0;
      end
    end else if (se) begin
      if (oc != 7'd0) m_paying = 1'b1;
      else m_locked = 1'b1;
    end
    red = m_locked || (m_paying && m_wrong > 0);
    return {m_open, red, m_open, m_locked, exited};
  endfunction

  task automatic step(input bit se, input bit sc, input bit pv, input logic [1:0] pc,
                      input bit at, input logic [6:0] oc);
    @(negedge clk);
    sensor_exit  = se;
    sensor_clear = sc;
    pay_valid    = pv;
    pay_code     = pc;
    attendant_ok = at;
    occupancy    = oc;
    exp_q.push_back(model_step(se, sc, pv, pc, at, oc));
  endtask

  // Scoreboard monitor: compares one queued expectation per clock.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("cycle", outs(), mon_e);
    end
  end

  initial begin
    reset        = 1'b1;
    sensor_exit  = 1'b0;
    sensor_clear = 1'b0;
    pay_valid    = 1'b0;
    pay_code     = 2'b00;
    attendant_ok = 1'b0;
    occupancy    = 7'd5;
    model_reset();
    #12;
    check("reset_state", outs(), 5'b00000);
    @(negedge clk);
    reset = 1'b0;
    #2;
    check("after_release", outs(), 5'b00000);

    // Paid exit followed by a back-to-back vehicle.
    step(1, 0, 0, 2'b00, 0, 7'd5);
    step(1, 0, 1, 2'b11, 0, 7'd5);
    step(1, 0, 0, 2'b00, 0, 7'd5);
    step(1, 1, 0, 2'b00, 0, 7'd5);
    step(1, 0, 0, 2'b00, 0, 7'd4);
    step(0, 0, 0, 2'b00, 0, 7'd4);
    step(0, 0, 0, 2'b00, 0, 7'd4);

    // Wrong codes to lockout, ignored good code, attendant release.
    step(1, 0, 0, 2'b00, 0, 7'd5);
    step(1, 0, 1, 2'b01, 0, 7'd5);
    step(1, 0, 1, 2'b10, 0, 7'd5);
    step(1, 0, 1, 2'b00, 0, 7'd5);
    step(1, 0, 1, 2'b11, 0, 7'd5);
    step(1, 0, 0, 2'b00, 1, 7'd5);
    step(0, 1, 0, 2'b00, 0, 7'd5);
    // Retry count must restart from zero after the override.
    step(1, 0, 0, 2'b00, 0, 7'd5);
    step(1, 0, 1, 2'b01, 0, 7'd5);
    step(1, 0, 1, 2'b01, 0, 7'd5);
    step(1, 0, 1, 2'b11, 0, 7'd5);
    step(0, 1, 0, 2'b00, 0, 7'd5);

    // Timeout with the lane empty, then held open by sensor_exit.
    step(1, 0, 0, 2'b00, 0, 7'd5);
    step(0, 0, 1, 2'b11, 0, 7'd5);
    for (int i = 0; i < GATE + 3; i++) step(0, 0, 0, 2'b00, 0, 7'd5);
    step(1, 0, 0, 2'b00, 0, 7'd5);
    step(1, 0, 1, 2'b11, 0, 7'd5);
    for (int i = 0; i < GATE + 6; i++) step(1, 0, 0, 2'b00, 0, 7'd5);
    step(1, 1, 0, 2'b00, 0, 7'd5);
    step(0, 0, 0, 2'b00, 0, 7'd5);

    // Phantom vehicle: empty car park, override, no decrement pulse.
    step(1, 0, 0, 2'b00, 0, 7'd0);
    step(1, 0, 1, 2'b11, 0, 7'd0);
    step(1, 0, 0, 2'b00, 1, 7'd0);
    step(0, 1, 0, 2'b00, 0, 7'd0);
    step(0, 0, 0, 2'b00, 0, 7'd0);

    // Withdrawal, then override winning over a wrong code.
    step(1, 0, 0, 2'b00, 0, 7'd3);
    step(0, 0, 0, 2'b00, 0, 7'd3);
    step(1, 0, 0, 2'b00, 0, 7'd3);
    step(1, 0, 1, 2'b01, 0, 7'd3);
    step(1, 0, 1, 2'b10, 1, 7'd3);
    step(0, 1, 0, 2'b00, 0, 7'd3);
    step(1, 0, 0, 2'b00, 0, 7'd3);
    step(1, 0, 1, 2'b01, 0, 7'd3);
    step(1, 0, 1, 2'b01, 0, 7'd3);
    step(1, 0, 1, 2'b01, 0, 7'd3);
    step(1, 0, 0, 2'b00, 1, 7'd3);

    // Reset asserted mid-OPEN drops the barrier at once, no pulse.
    step(1, 1, 0, 2'b00, 0, 7'd3);
    step(1, 0, 0, 2'b00, 0, 7'd3);
    step(1, 0, 1, 2'b11, 0, 7'd3);
    @(posedge clk);
    #2;
    sensor_clear = 1'b1;
    reset = 1'b1;
    #1;
    check("reset_mid_open", outs(), 5'b00000);
    model_reset();
    @(posedge clk);
    #2;
    check("reset_held", outs(), 5'b00000);
    @(negedge clk);
    sensor_clear = 1'b0;
    sensor_exit  = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    #2;
    check("reset_released_idle", outs(), 5'b00000);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 3) != 0),
           ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 3) == 0),
           2'($urandom_range(0, 3)),
           ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 7) == 0) ? 7'd0 : 7'($urandom_range(1, 99)));
    end
    step(0, 0, 0, 2'b00, 0, 7'd5);

    @(posedge clk);
    #3;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
